armleosoc_clint_access_arbiter: RTL and testbench

//  Round-robin arbiter that shares the CLINT register port among REQ_COUNT requesters.

---
 rtl/armleosoc_clint_access_arbiter_if.sv | 37 +++
 rtl/armleosoc_clint_access_arbiter.sv | 139 +++++++++++++
 tb/tb_armleosoc_clint_access_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/armleosoc_clint_access_arbiter_if.sv
// Requester-side and downstream register-port signals of the CLINT access arbiter.
// The arbiter connects through the slave modport; requesters and the peripheral use master.
interface armleosoc_clint_access_arbiter_if #(
  parameter int REQ_COUNT = 4
);
  logic [REQ_COUNT-1:0]    req_valid;
  logic [REQ_COUNT-1:0]    req_ready;
  logic [REQ_COUNT-1:0]    req_write;
  logic [REQ_COUNT*16-1:0] req_address;
  logic [REQ_COUNT*32-1:0] req_wdata;
  logic [REQ_COUNT*4-1:0]  req_wbe;
  logic [REQ_COUNT-1:0]    resp_valid;
  logic [REQ_COUNT-1:0]    resp_ready;
  logic [31:0]             resp_rdata;
  logic                    resp_error;
  logic [15:0]             address;
  logic                    write;
  logic                    read;
  logic [31:0]             write_data;
  logic [3:0]              write_byteenable;
  logic [31:0]             read_data;
  logic                    address_error;

  modport slave (
    input  req_valid, req_write, req_address, req_wdata, req_wbe, resp_ready,
           read_data, address_error,
    output req_ready, resp_valid, resp_rdata, resp_error, address, write, read,
           write_data, write_byteenable
  );

  modport master (
    output req_valid, req_write, req_address, req_wdata, req_wbe, resp_ready,
           read_data, address_error,
    input  req_ready, resp_valid, resp_rdata, resp_error, address, write, read,
           write_data, write_byteenable
  );
endinterface

// File: rtl/armleosoc_clint_access_arbiter.sv
// Round-robin arbiter sharing one CLINT register port among REQ_COUNT requesters,
// one single-beat read or write at a time.
//
// state    | meaning
// S_IDLE   | scan requesters from rr_ptr, accept the first valid one
// S_ACCESS | one-cycle downstream access from the latched request
// S_RESP   | hold response to the granted requester until resp_ready
module armleosoc_clint_access_arbiter #(
  parameter int REQ_COUNT = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  armleosoc_clint_access_arbiter_if.slave bus
);
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = 4;
  localparam int PTR_W      = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        grant_q;
  logic [PTR_W-1:0]        grant_idx;
  logic [PTR_W-1:0]        scan_idx;
  logic                    grant_found;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wbe_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic                    misaligned;

  assign misaligned = (addr_q[1:0] != 2'b00);

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int i = REQ_COUNT - 1; i >= 0; i--) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + i) % REQ_COUNT);
      if (bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          state_d  = S_ACCESS;
          rr_ptr_d = (grant_idx == PTR_W'(REQ_COUNT - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP: begin
        if (bus.resp_ready[grant_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) bus.req_ready[grant_idx] = 1'b1;
      end
      S_ACCESS: begin
        if (!misaligned) begin
          bus.write = write_q;
          bus.read  = !write_q;
        end
      end
      S_RESP: bus.resp_valid[grant_q] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wbe_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && grant_found) begin
        grant_q <= grant_idx;
        write_q <= bus.req_write[grant_idx];
        addr_q  <= bus.req_address[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_q <= bus.req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        wbe_q   <= bus.req_wbe[int'(grant_idx)*STRB_WIDTH +: STRB_WIDTH];
      end
      // Misaligned accesses never reach the peripheral, so its error input is ignored.
      if (state_q == S_ACCESS) begin
        if (misaligned) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end else begin
          err_q   <= bus.address_error;
          rdata_q <= (!write_q && !bus.address_error) ? bus.read_data : '0;
        end
      end
    end
  end

  assign bus.address          = addr_q;
  assign bus.write_data       = wdata_q;
  assign bus.write_byteenable = wbe_q;
  assign bus.resp_rdata       = rdata_q;
  assign bus.resp_error       = err_q;
endmodule

// File: tb/tb_armleosoc_clint_access_arbiter.sv
// Directed bench for the CLINT access arbiter: single write, read, round-robin order,
// misaligned access, downstream error with stalled response, and reset during RESP.
module tb_armleosoc_clint_access_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  armleosoc_clint_access_arbiter_if #(.REQ_COUNT(N)) bus ();

  armleosoc_clint_access_arbiter #(.REQ_COUNT(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    bus.req_write[i]         = wr;
    bus.req_address[i*16+:16] = a;
    bus.req_wdata[i*32+:32]   = d;
    bus.req_wbe[i*4+:4]       = be;
  endtask

  task automatic test_reset();
    bus.req_valid = '0; bus.req_write = '0; bus.req_address = '0;
    bus.req_wdata = '0; bus.req_wbe = '0; bus.resp_ready = '0;
    bus.read_data = '0; bus.address_error = 1'b0;
    rst_n = 1'b0;
    #12;
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0000", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 4'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0000", bus.resp_valid); end
    n_cmp++; if ({bus.write, bus.read, bus.resp_error} !== 3'b000) begin n_err++; $display("FAIL rst_strobes: got %b want 000", {bus.write, bus.read, bus.resp_error}); end
    n_cmp++; if ({bus.address, bus.write_data, bus.write_byteenable, bus.resp_rdata} !== 84'h0) begin n_err++; $display("FAIL rst_datapath: got %h want 0", {bus.address, bus.write_data, bus.write_byteenable, bus.resp_rdata}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    step();
    set_req(0, 1'b1, 16'h4000, 32'hDEADBEEF, 4'hF);
    bus.req_valid = 4'b0001;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL wr_ready: got %b want 0001", bus.req_ready); end
    step();
    bus.req_valid = '0;
    #1;
    n_cmp++; if ({bus.write, bus.read} !== 2'b10) begin n_err++; $display("FAIL wr_strobe: got %b want 10", {bus.write, bus.read}); end
    n_cmp++; if (bus.address !== 16'h4000) begin n_err++; $display("FAIL wr_address: got %h want 4000", bus.address); end
    n_cmp++; if ({bus.write_data, bus.write_byteenable} !== {32'hDEADBEEF, 4'hF}) begin n_err++; $display("FAIL wr_payload: got %h want deadbeeff", {bus.write_data, bus.write_byteenable}); end
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL wr_ready_access: got %b want 0000", bus.req_ready); end
    step();
    #1;
    n_cmp++; if (bus.resp_valid !== 4'b0001) begin n_err++; $display("FAIL wr_resp_valid: got %b want 0001", bus.resp_valid); end
    n_cmp++; if ({bus.resp_error, bus.write} !== 2'b00) begin n_err++; $display("FAIL wr_resp_err_strobe: got %b want 00", {bus.resp_error, bus.write}); end
    bus.resp_ready = 4'b0001;
    step();
    #1;
    n_cmp++; if (bus.resp_valid !== 4'b0) begin n_err++; $display("FAIL wr_resp_drop: got %b want 0000", bus.resp_valid); end
    bus.resp_ready = '0;
  endtask

  task automatic test_read();
    step();
    set_req(1, 1'b0, 16'hBFF8, 32'h0, 4'hF);
    bus.read_data = 32'h12345678;
    bus.req_valid = 4'b0010;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL rd_ready: got %b want 0010", bus.req_ready); end
    step();
    bus.req_valid = '0;
    #1;
    n_cmp++; if ({bus.write, bus.read} !== 2'b01) begin n_err++; $display("FAIL rd_strobe: got %b want 01", {bus.write, bus.read}); end
    n_cmp++; if (bus.address !== 16'hBFF8) begin n_err++; $display("FAIL rd_address: got %h want bff8", bus.address); end
    step();
    #1;
    n_cmp++; if (bus.read !== 1'b0) begin n_err++; $display("FAIL rd_strobe_once: got %b want 0", bus.read); end
    n_cmp++; if (bus.resp_valid !== 4'b0010) begin n_err++; $display("FAIL rd_resp_valid: got %b want 0010", bus.resp_valid); end
    n_cmp++; if (bus.resp_rdata !== 32'h12345678) begin n_err++; $display("FAIL rd_rdata: got %h want 12345678", bus.resp_rdata); end
    n_cmp++; if (bus.resp_error !== 1'b0) begin n_err++; $display("FAIL rd_error: got %b want 0", bus.resp_error); end
    bus.resp_ready = 4'b0010;
    step();
    #1;
    n_cmp++; if (bus.resp_valid !== 4'b0) begin n_err++; $display("FAIL rd_resp_drop: got %b want 0000", bus.resp_valid); end
    bus.resp_ready = '0;
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int cnt [N];
    int k;
    for (int j = 0; j < N; j++) begin
      cnt[j] = 0;
      set_req(j, 1'b0, 16'(16'h0100 + 16'(j * 4)), 32'h0, 4'hF);
    end
    step();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bus.read_data  = 32'h0;
    bus.resp_ready = 4'hF;
    step();
    bus.req_valid = 4'hF;
    k = 0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      #1;
      if (bus.req_ready != 4'b0) begin
        n_cmp++; if (bus.req_ready !== 4'(1 << order[k])) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", k, bus.req_ready, 4'(1 << order[k])); end
        for (int j = 0; j < N; j++) cnt[j] += int'(bus.req_ready[j]);
        k++;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    n_cmp++; if (k != 5) begin n_err++; $display("FAIL rr_timeout: got %0d grants want 5", k); end
    n_cmp++; if (cnt[0] != 2) begin n_err++; $display("FAIL rr_count0: got %0d want 2", cnt[0]); end
    for (int j = 1; j < N; j++) begin
      n_cmp++; if (cnt[j] != 1) begin n_err++; $display("FAIL rr_count%0d: got %0d want 1", j, cnt[j]); end
    end
    step();
    step();
    n_cmp++; if (bus.resp_valid !== 4'b0) begin n_err++; $display("FAIL rr_drain: got %b want 0000", bus.resp_valid); end
    bus.resp_ready = '0;
  endtask

  // rr_ptr is 1 here, so requester 2 wins.
  task automatic test_misaligned();
    step();
    set_req(2, 1'b0, 16'h4002, 32'h0, 4'hF);
    bus.read_data = 32'hFFFFFFFF;
    bus.req_valid = 4'b0100;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL mis_ready: got %b want 0100", bus.req_ready); end
    step();
    bus.req_valid = '0;
    #1;
    n_cmp++; if ({bus.write, bus.read} !== 2'b00) begin n_err++; $display("FAIL mis_strobe: got %b want 00", {bus.write, bus.read}); end
    step();
    #1;
    n_cmp++; if (bus.resp_valid !== 4'b0100) begin n_err++; $display("FAIL mis_resp_valid: got %b want 0100", bus.resp_valid); end
    n_cmp++; if ({bus.resp_error, bus.resp_rdata} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL mis_resp: got %h want 100000000", {bus.resp_error, bus.resp_rdata}); end
    bus.resp_ready = 4'b0100;
    step();
    bus.resp_ready = '0;
  endtask

  // rr_ptr is 3 here.
  task automatic test_addr_error();
    set_req(3, 1'b0, 16'h3FF0, 32'h0, 4'hF);
    bus.read_data     = 32'hA5A5A5A5;
    bus.address_error = 1'b1;
    bus.req_valid     = 4'b1000;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL err_ready: got %b want 1000", bus.req_ready); end
    step();
    bus.req_valid = '0;
    #1;
    n_cmp++; if ({bus.read, bus.address} !== {1'b1, 16'h3FF0}) begin n_err++; $display("FAIL err_access: got %h want 13ff0", {bus.read, bus.address}); end
    for (int c = 0; c < 5; c++) begin
      step();
      #1;
      n_cmp++; if ({bus.resp_valid, bus.resp_error, bus.resp_rdata} !== {4'b1000, 1'b1, 32'h0}) begin n_err++; $display("FAIL err_hold%0d: got %h want 1100000000", c, {bus.resp_valid, bus.resp_error, bus.resp_rdata}); end
    end
    bus.resp_ready = 4'b1000;
    step();
    #1;
    n_cmp++; if (bus.resp_valid !== 4'b0) begin n_err++; $display("FAIL err_resp_drop: got %b want 0000", bus.resp_valid); end
    bus.resp_ready    = '0;
    bus.address_error = 1'b0;
  endtask

  // rr_ptr is 0 here; requester 2 wins, then the reset must put rr_ptr back to 0.
  task automatic test_reset_mid();
    step();
    set_req(2, 1'b1, 16'h0008, 32'h11111111, 4'h3);
    bus.req_valid = 4'b0100;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL rm_ready: got %b want 0100", bus.req_ready); end
    step();
    bus.req_valid = '0;
    step();
    #1;
    n_cmp++; if (bus.resp_valid !== 4'b0100) begin n_err++; $display("FAIL rm_resp_valid: got %b want 0100", bus.resp_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.resp_valid !== 4'b0) begin n_err++; $display("FAIL rm_resp_abort: got %b want 0000", bus.resp_valid); end
    n_cmp++; if ({bus.write, bus.read, bus.resp_error, bus.address, bus.write_data} !== 51'h0) begin n_err++; $display("FAIL rm_outputs: got %h want 0", {bus.write, bus.read, bus.resp_error, bus.address, bus.write_data}); end
    rst_n = 1'b1;
    step();
    set_req(1, 1'b0, 16'h0020, 32'h0, 4'hF);
    set_req(3, 1'b0, 16'h0030, 32'h0, 4'hF);
    bus.resp_ready = 4'hF;
    bus.req_valid  = 4'b1010;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL rm_regrant: got %b want 0010", bus.req_ready); end
    step();
    bus.req_valid = 4'b1000;
    step();
    step();
    #1;
    n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL rm_next_grant: got %b want 1000", bus.req_ready); end
    step();
    bus.req_valid = '0;
    step();
    step();
    bus.resp_ready = '0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_round_robin();
    test_misaligned();
    test_addr_error();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1);
  end
endmodule
